// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared logic unit arbiter
// and its single consumer. Signal names keep the arbiter's _i/_o point of view.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds valid and payload stable until then, and ready never depends
  // on anything the sender drives in the same cycle other than valid itself.
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [3*NREQ-1:0]     req_op_i;
  logic [WIDTH*NREQ-1:0] req_a_i;
  logic [WIDTH*NREQ-1:0] req_b_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      rsp_data_o;
  logic                  rsp_err_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters,
// with a one-entry registered response slot tagged by requester index.
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  logic_op_arbiter_if.slave    bus,
  output logic                 dbg_state_o
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

  slot_state_t      state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             found;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   idx;
  logic [NREQ-1:0]  grant;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] result;
  logic             op_err;

  assign slot_free = (state_q == S_EMPTY) | bus.rsp_ready_i;

  // Rotating priority search; nothing is granted while reset is high.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    if (!rst_i && slot_free) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
        if (!found && bus.req_valid_i[idx]) begin
          found       = 1'b1;
          gidx        = idx;
          grant[idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_op = bus.req_op_i[3*int'(gidx) +: 3];
    sel_a  = bus.req_a_i[WIDTH*int'(gidx) +: WIDTH];
    sel_b  = bus.req_b_i[WIDTH*int'(gidx) +: WIDTH];
    result = '0;
    op_err = 1'b0;
    case (sel_op)
      3'd0:    result = ~sel_a;
      3'd1:    result = sel_a & sel_b;
      3'd2:    result = ~(sel_a & sel_b);
      3'd3:    result = ~(sel_a | sel_b);
      3'd4:    result = sel_a | sel_b;
      3'd5:    result = sel_a ^ sel_b;
      3'd6:    result = ~(sel_a ^ sel_b);
      default: op_err = 1'b1;
    endcase
  end

  // A grant always (re)loads the slot, which covers drain-and-reload without a bubble.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    err_d    = err_q;
    if (found) begin
      state_d  = S_FULL;
      id_d     = gidx;
      data_d   = result;
      err_d    = op_err;
      rr_ptr_d = IDW'((int'(gidx) + 1) % NREQ);
    end else if (state_q == S_FULL && bus.rsp_ready_i) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      rr_ptr_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = (state_q == S_FULL);
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.busy_o      = (state_q == S_FULL) | (|bus.req_valid_i);
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural slot model.
module tb_logic_op_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_vec;
  int   n_err;

  logic_op_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  logic_op_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  bit             m_live;
  bit             m_valid;
  int             m_id;
  int             m_ptr;
  logic [WIDTH-1:0] m_data;
  bit             m_err;

  function automatic logic [WIDTH-1:0] model_op(int op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (op)
      0:       return ~a;
      1:       return a & b;
      2:       return ~(a & b);
      3:       return ~(a | b);
      4:       return a | b;
      5:       return a ^ b;
      6:       return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  // Index that should be granted this cycle, or -1.
  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid && !bus.rsp_ready_i) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (bus.req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_valid = 0; m_id = 0; m_ptr = 0; m_data = '0; m_err = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        int op;
        op      = int'(bus.req_op_i[3*g +: 3]);
        m_valid = 1;
        m_id    = g;
        m_data  = model_op(op, bus.req_a_i[WIDTH*g +: WIDTH], bus.req_b_i[WIDTH*g +: WIDTH]);
        m_err   = (op == 7);
        m_ptr   = (g + 1) % NREQ;
      end else if (bus.rsp_ready_i) begin
        m_valid = 0;
      end
    end
    m_live = 1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] eg;
    if (m_live) begin
      g  = model_grant();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready_o), 32'(eg));
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_valid));
      chk("dbg_state", 32'(dbg_state), 32'(m_valid));
      chk("busy", 32'(bus.busy_o), 32'(m_valid | (|bus.req_valid_i)));
      if (m_valid) begin
        chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_id));
        chk("rsp_data", 32'(bus.rsp_data_o), 32'(m_data));
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(m_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op_i[3*k +: 3]        = 3'(op);
    bus.req_a_i[WIDTH*k +: WIDTH] = a;
    bus.req_b_i[WIDTH*k +: WIDTH] = b;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    bus.req_valid_i = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] op_tab [8];

  initial begin
    n_vec = 0; n_err = 0; m_live = 0;
    op_tab = '{8'h5A, 8'h24, 8'hDB, 8'h42, 8'hBD, 8'h99, 8'h66, 8'h00};
    rst = 1'b1;
    bus.req_valid_i = '0; bus.req_op_i = '0; bus.req_a_i = '0; bus.req_b_i = '0;
    bus.rsp_ready_i = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_valid", 32'(bus.rsp_valid_o), 0);
      chk("idle_data", 32'(bus.rsp_data_o), 0);
      chk("idle_id", 32'(bus.rsp_id_o), 0);
      chk("idle_err", 32'(bus.rsp_err_o), 0);
      chk("idle_busy", 32'(bus.busy_o), 0);
    end

    // All opcodes from requester 2
    bus.rsp_ready_i = 1'b1;
    for (int op = 0; op < 8; op++) begin
      next_cycle();
      set_req(2, op, 8'hA5, 8'h3C);
      bus.req_valid_i = 4'b0100;
      @(negedge clk);
      chk("op_grant", 32'(bus.req_ready_o), 32'h4);
      next_cycle();
      bus.req_valid_i = '0;
      @(negedge clk);
      chk("op_valid", 32'(bus.rsp_valid_o), 1);
      chk("op_data", 32'(bus.rsp_data_o), 32'(op_tab[op]));
      chk("op_id", 32'(bus.rsp_id_o), 2);
      chk("op_err", 32'(bus.rsp_err_o), (op == 7) ? 1 : 0);
    end

    // Round-robin from reset
    do_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, k, 8'(k * 17), 8'hF0);
    bus.req_valid_i = 4'hF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready_o), 32'(1 << (i % 4)));
      if (i > 0) chk("rr_id", 32'(bus.rsp_id_o), 32'((i - 1) % 4));
      next_cycle();
    end

    // Backpressure
    do_reset();
    set_req(1, 1, 8'hF0, 8'h3C);
    set_req(3, 5, 8'h0F, 8'hFF);
    bus.req_valid_i = 4'b0010;
    @(negedge clk);
    chk("bp_fill", 32'(bus.req_ready_o), 32'h2);
    next_cycle();
    bus.req_valid_i = 4'b1000;
    bus.rsp_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready_o), 0);
      chk("bp_id", 32'(bus.rsp_id_o), 1);
      chk("bp_data", 32'(bus.rsp_data_o), 32'h30);
      next_cycle();
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(bus.req_ready_o), 32'h8);
    next_cycle();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("bp_id3", 32'(bus.rsp_id_o), 3);
    chk("bp_data3", 32'(bus.rsp_data_o), 32'hF0);

    // Reset while FULL
    next_cycle();
    rst = 1'b1;
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 0);
    next_cycle();
    rst = 1'b0;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("rst_drop", 32'(bus.rsp_valid_o), 0);

    // Wrap and skip
    bus.rsp_ready_i = 1'b1;
    next_cycle();
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    chk("wrap_g2", 32'(bus.req_ready_o), 32'h4);
    next_cycle();
    bus.req_valid_i = 4'b0110;
    @(negedge clk);
    chk("wrap_g1", 32'(bus.req_ready_o), 32'h2);
    next_cycle();
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    chk("wrap_g2b", 32'(bus.req_ready_o), 32'h4);
    next_cycle();
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("skip_hold", 32'(bus.req_ready_o), 0);
    next_cycle();
    bus.req_valid_i = 4'b0100;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("skip_g2", 32'(bus.req_ready_o), 32'h4);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      rst             = ($urandom_range(0, 99) == 0);
      bus.req_valid_i = NREQ'($urandom);
      bus.req_op_i    = (3*NREQ)'($urandom);
      bus.req_a_i     = (WIDTH*NREQ)'($urandom);
      bus.req_b_i     = (WIDTH*NREQ)'($urandom);
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    next_cycle();
    rst = 1'b0;
    bus.req_valid_i = '0;
    @(negedge clk);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
